powlib_sfifo: RTL and testbench
===============================

# powlib_sfifo

Synchronous single-clock FIFO controller. It sequences one `powlib_dpram` instance through valid/ready push and pop ports, using two `powlib_cntr` pointers and a registered occupancy counter. The read side is first-word-fall-through: data is taken straight from the RAM's asynchronous read port. It is the standard buffering stage between powlib pipeline producers and consumers that run on the same clock.

## Interface
- `W`, 32: data width in bits.
- `D`, 8: depth in words. Must be ≥2. Powers of two are not required.
- `AFT`, D-2: almost-full threshold. `afull` is asserted when `cnt` ≥ `AFT`. Legal range 1..D.
- `WIDX`, powlib_clogb2(D): pointer width.
- `WCNT`, powlib_clogb2(D+1): occupancy width.
- `EAR`, 0: reserved. Must be 0; reset is synchronous.

Ports:
- `clk`  in  1  clock. All logic samples on the rising edge.
- `rst`  in  1  reset: synchronous, active-high.
- `wrdata`  in  W  push data.
- `wrvld`  in  1  push request.
- `wrrdy`  out  1  push accepted when `wrvld` and `wrrdy` are both 1 at an edge.
- `rddata`  out  W  head-of-queue data. Only meaningful while `rdvld` is 1.
- `rdvld`  out  1  queue non-empty.
- `rdrdy`  in  1  pop when `rdvld` and `rdrdy` are both 1 at an edge.
- `cnt`  out  WCNT  current occupancy, 0..D.
- `afull`  out  1  registered almost-full flag.

## Operation
- Submodules:
  - `powlib_dpram` (W, D): `wridx`=wrptr, `wrdata`=`wrdata`, `wrvld`=push, `rdidx`=rdptr, `rddata`=`rddata`, `EWBE`=0.
  - `wrptr` and `rdptr` are `powlib_cntr` instances with W=WIDX, X=1. Each uses `adv`=push/pop. Each uses `clr`=`rst` or (`adv` and ptr==D-1), giving an explicit wrap D-1→0.
- Definitions:
  - push = `wrvld` & `wrrdy`.
  - pop = `rdvld` & `rdrdy`.
  - `wrrdy` = (`cnt`!=D).
  - `rdvld` = (`cnt`!=0).
- Occupancy: `cnt` <= `cnt`+1 on push only, `cnt`-1 on pop only, unchanged on both or neither. It never exceeds D or goes below 0.
- Full: `wrrdy`=0 regardless of `rdrdy`. There is no same-cycle write-through when full, so a pop during full frees the slot from the next cycle onward.
- Empty: `rdvld`=0 and `rddata` is don't-care. A push in the same cycle is accepted. The word appears on `rddata` in the next cycle; there is no bypass.
- Simultaneous push and pop (0<`cnt`<D): both pointers advance and `cnt` holds.
- `afull` <= (next `cnt` ≥ `AFT`). It is registered from next-state occupancy, so it is exact in the same cycle as `cnt`.
- Reset:
  - `wrptr`, `rdptr` and `cnt` go to 0; `afull` goes to 0 (or 1 if `AFT`=0 is forced, which is illegal).
  - `wrrdy`=1 and `rdvld`=0 from the first cycle after reset.
  - RAM contents are not cleared.
  - A push or pop presented in the reset cycle is ignored.
  - Reset mid-operation discards all queued words.
- `wrvld` and `rdrdy` may be asserted without the matching ready/valid. Nothing happens in that case, and the FIFO imposes no hold requirement on them.

## Timing
- Push to visible output: 1 cycle. A word written at edge N appears on `rddata` with `rdvld`=1 after edge N, if it is at the head.
- Pop to next word: `rddata` changes to the next entry combinationally after the pop edge. Throughput is 1 word/cycle sustained in both directions.
- `wrrdy`, `rdvld`, `cnt` and `afull` all depend only on registers. There is no combinational path from `wrvld` or `rdrdy` to any output.
- `rddata` is a combinational function of `rdptr` and RAM contents.
- Write order equals read order across any number of pointer wraps.

## Test plan
- Reset then idle: `cnt`=0, `rdvld`=0, `wrrdy`=1, `afull`=0 for 10 cycles.
- Fill then drain (D=4, AFT=3, no pops):
  - Push 0xA0..0xA3 on consecutive cycles. `cnt` goes 1,2,3,4; `afull` rises together with `cnt`=3; `wrrdy`=0 after the 4th push.
  - A 5th push of 0xA4 is refused and `cnt` stays 4.
  - Then pop continuously: data 0xA0..0xA3 in order; `rdvld` drops after the 4th pop.
- Empty push/pop: from empty, hold `rdrdy`=1 and push 0x55. `rdvld`=1 and `rddata`=0x55 on the next cycle, and the pop happens on that cycle's edge. `cnt` goes 0,1,0.
- Full with simultaneous pop (D=4, full):
  - `wrvld`=1 and `rdrdy`=1 for one cycle: only the pop occurs and `cnt`=3.
  - Next cycle, push and pop together: `cnt` stays 3.
- Wrap (D=5, non-power-of-two): stream 23 words (0x00..0x16) with random `wrvld`/`rdrdy`. Output sequence is identical, with no loss or duplication, and `cnt` always matches a reference model.
- Reset mid-operation: with 3 words queued, assert `rst` together with `wrvld`=1 for 1 cycle. Next cycle `cnt`=0 and `rdvld`=0. A subsequent push of 0x77 reads back 0x77 first.

Source files
------------

// File: rtl/powlib_sfifo.sv
// Single-clock first-word-fall-through FIFO: dual-port RAM sequenced by two
// wrapping pointer counters and a registered occupancy counter.

module powlib_cntr #(
    parameter int W = 4,
    parameter int X = 1
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         adv,
    output logic [W-1:0] cntr
);

    // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (clr)
            cntr <= '0;
        else if (adv)
            cntr <= cntr + W'(X);
    end

endmodule

module powlib_dpram #(
    parameter int W    = 32,
    parameter int D    = 8,
    parameter int EWBE = 0,
    parameter int WIDX = $clog2(D)
) (
    input  logic            clk,
    input  logic [WIDX-1:0] wridx,
    input  logic [W-1:0]    wrdata,
    input  logic            wrvld,
    input  logic [WIDX-1:0] rdidx,
    output logic [W-1:0]    rddata
);

    logic [W-1:0] mem [D];

    if (EWBE != 0) begin : g_ewbe_unsupported
        $error("powlib_dpram: byte-enable writes are not supported");
    end

    // NOTE: storage is deliberately left unreset; occupancy logic guards every read.
    always_ff @(posedge clk) begin
        if (wrvld)
            mem[wridx] <= wrdata;
    end

    assign rddata = mem[rdidx];

endmodule

module powlib_sfifo #(
    parameter int W    = 32,
    parameter int D    = 8,
    parameter int AFT  = D - 2,
    parameter int WIDX = $clog2(D),
    parameter int WCNT = $clog2(D + 1),
    parameter int EAR  = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [W-1:0]    wrdata,
    input  logic            wrvld,
    output logic            wrrdy,
    output logic [W-1:0]    rddata,
    output logic            rdvld,
    input  logic            rdrdy,
    output logic [WCNT-1:0] cnt,
    output logic            afull
);

    if (EAR != 0) begin : g_ear_unsupported
        $error("powlib_sfifo: only synchronous reset (EAR=0) is supported");
    end

    logic            push;
    logic            pop;
    logic            wrclr;
    logic            rdclr;
    logic [WIDX-1:0] wrptr;
    logic [WIDX-1:0] rdptr;
    logic [WCNT-1:0] cnt_nxt;

    // Handshake flags come only from the occupancy register, never from inputs.
    assign wrrdy = (cnt != WCNT'(D));
    assign rdvld = (cnt != '0);
    assign push  = wrvld & wrrdy;
    assign pop   = rdvld & rdrdy;

    assign wrclr = rst | (push & (wrptr == WIDX'(D - 1)));
    assign rdclr = rst | (pop  & (rdptr == WIDX'(D - 1)));

    powlib_cntr #(.W(WIDX), .X(1)) u_wrptr (
        .clk  (clk),
        .clr  (wrclr),
        .adv  (push),
        .cntr (wrptr)
    );

    powlib_cntr #(.W(WIDX), .X(1)) u_rdptr (
        .clk  (clk),
        .clr  (rdclr),
        .adv  (pop),
        .cntr (rdptr)
    );

    powlib_dpram #(.W(W), .D(D), .EWBE(0), .WIDX(WIDX)) u_ram (
        .clk    (clk),
        .wridx  (wrptr),
        .wrdata (wrdata),
        .wrvld  (push),
        .rdidx  (rdptr),
        .rddata (rddata)
    );

    // NOTE: the default assignment first keeps this block free of inferred latches.
    always_comb begin
        cnt_nxt = cnt;
        case ({push, pop})
            2'b10:   cnt_nxt = cnt + 1'b1;
            2'b01:   cnt_nxt = cnt - 1'b1;
            default: cnt_nxt = cnt;
        endcase
    end

    // afull is computed from next-state occupancy so it lines up with cnt.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            afull <= 1'(AFT == 0);
        end else begin
            cnt   <= cnt_nxt;
            afull <= (cnt_nxt >= WCNT'(AFT));
        end
    end

endmodule

// File: tb/tb_powlib_sfifo.sv
// Scoreboard bench for powlib_sfifo: a D=4/AFT=3 instance for directed
// scenarios and a D=5 instance for pointer-wrap streaming.

module tb_powlib_sfifo;

    logic clk = 1'b0;
    logic rst;

    logic [7:0] wrdata4, rddata4, wrdata5, rddata5;
    logic       wrvld4, wrrdy4, rdvld4, rdrdy4, afull4;
    logic       wrvld5, wrrdy5, rdvld5, rdrdy5, afull5;
    logic [2:0] cnt4, cnt5;

    int total  = 0;
    int passed = 0;

    logic [7:0] exp4[$];
    logic [7:0] exp5[$];

    always #5 clk = ~clk;

    powlib_sfifo #(.W(8), .D(4), .AFT(3)) u_d4 (
        .clk(clk), .rst(rst),
        .wrdata(wrdata4), .wrvld(wrvld4), .wrrdy(wrrdy4),
        .rddata(rddata4), .rdvld(rdvld4), .rdrdy(rdrdy4),
        .cnt(cnt4), .afull(afull4)
    );

    powlib_sfifo #(.W(8), .D(5), .AFT(3)) u_d5 (
        .clk(clk), .rst(rst),
        .wrdata(wrdata5), .wrvld(wrvld5), .wrrdy(wrrdy5),
        .rddata(rddata5), .rdvld(rdvld5), .rdrdy(rdrdy5),
        .cnt(cnt5), .afull(afull5)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp)
            passed++;
        else
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitors: every pop the DUT performs is compared with the scoreboard head.
    always @(negedge clk) begin
        if (!rst && rdvld4 && rdrdy4) begin
            if (exp4.size() == 0)
                check("d4 unexpected pop", {24'h0, rddata4}, 32'hFFFF_FFFF);
            else
                check("d4 pop data", {24'h0, rddata4}, {24'h0, exp4.pop_front()});
        end
    end

    always @(negedge clk) begin
        if (!rst && rdvld5 && rdrdy5) begin
            if (exp5.size() == 0)
                check("d5 unexpected pop", {24'h0, rddata5}, 32'hFFFF_FFFF);
            else
                check("d5 pop data", {24'h0, rddata5}, {24'h0, exp5.pop_front()});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int m;
        int next_word;
        int cycles;
        logic do_push, do_pop;

        rst = 1'b1;
        wrdata4 = '0; wrvld4 = 1'b0; rdrdy4 = 1'b0;
        wrdata5 = '0; wrvld5 = 1'b0; rdrdy5 = 1'b0;
        step();
        step();
        rst = 1'b0;

        // Reset then idle
        for (int i = 0; i < 10; i++) begin
            step();
            check("idle cnt",   cnt4,   0);
            check("idle rdvld", rdvld4, 0);
            check("idle wrrdy", wrrdy4, 1);
            check("idle afull", afull4, 0);
        end
        check("d5 idle cnt", cnt5, 0);

        // Fill without pops
        for (int i = 0; i < 4; i++) begin
            wrdata4 = 8'hA0 + 8'(i);
            wrvld4  = 1'b1;
            exp4.push_back(wrdata4);
            step();
            check("fill cnt",   cnt4,   i + 1);
            check("fill afull", afull4, (i + 1 >= 3) ? 1 : 0);
            check("fill wrrdy", wrrdy4, (i < 3) ? 1 : 0);
        end
        wrdata4 = 8'hA4;
        step();
        check("refused push cnt", cnt4, 4);
        check("refused push wrrdy", wrrdy4, 0);
        wrvld4 = 1'b0;

        // Drain continuously
        rdrdy4 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("drain cnt",   cnt4,   3 - i);
            check("drain rdvld", rdvld4, (i < 3) ? 1 : 0);
        end
        rdrdy4 = 1'b0;
        check("drain afull", afull4, 0);

        // Push into empty with rdrdy held high
        rdrdy4  = 1'b1;
        wrvld4  = 1'b1;
        wrdata4 = 8'h55;
        exp4.push_back(8'h55);
        check("empty push pre cnt", cnt4, 0);
        step();
        wrvld4 = 1'b0;
        check("empty push cnt",    cnt4,    1);
        check("empty push rdvld",  rdvld4,  1);
        check("empty push rddata", rddata4, 8'h55);
        step();
        check("empty pop cnt", cnt4, 0);
        rdrdy4 = 1'b0;

        // Full with simultaneous pop, then push+pop together
        for (int i = 0; i < 4; i++) begin
            wrdata4 = 8'hB0 + 8'(i);
            wrvld4  = 1'b1;
            exp4.push_back(wrdata4);
            step();
        end
        check("full cnt", cnt4, 4);
        wrdata4 = 8'hB4;
        rdrdy4  = 1'b1;
        step();
        check("full pop-only cnt", cnt4, 3);
        wrdata4 = 8'hB5;
        exp4.push_back(8'hB5);
        step();
        check("push+pop cnt", cnt4, 3);
        wrvld4 = 1'b0;
        for (int i = 0; i < 3; i++) step();
        check("after full drain cnt", cnt4, 0);
        rdrdy4 = 1'b0;

        // Wrap on D=5 with random handshakes against a reference occupancy model
        m = 0;
        next_word = 0;
        cycles = 0;
        while ((next_word < 23 || m != 0) && cycles < 1000) begin
            wrvld5  = (next_word < 23) && ($urandom_range(0, 1) == 1);
            rdrdy5  = ($urandom_range(0, 2) != 0);
            wrdata5 = 8'(next_word);
            do_push = wrvld5 && (m != 5);
            do_pop  = rdrdy5 && (m != 0);
            if (do_push) begin
                exp5.push_back(wrdata5);
                next_word++;
            end
            step();
            m = m + (do_push ? 1 : 0) - (do_pop ? 1 : 0);
            check("wrap cnt", cnt5, m);
            cycles++;
        end
        wrvld5 = 1'b0;
        rdrdy5 = 1'b0;
        check("wrap completed in budget", (cycles < 1000) ? 1 : 0, 1);
        check("wrap words sent", next_word, 23);

        // Reset mid-operation
        for (int i = 0; i < 3; i++) begin
            wrdata4 = 8'hC0 + 8'(i);
            wrvld4  = 1'b1;
            exp4.push_back(wrdata4);
            step();
        end
        wrvld4 = 1'b0;
        check("pre-reset cnt", cnt4, 3);
        rst     = 1'b1;
        wrvld4  = 1'b1;
        wrdata4 = 8'hC3;
        step();
        rst    = 1'b0;
        wrvld4 = 1'b0;
        exp4.delete();
        check("post-reset cnt",   cnt4,   0);
        check("post-reset rdvld", rdvld4, 0);
        check("post-reset wrrdy", wrrdy4, 1);
        check("post-reset afull", afull4, 0);
        wrdata4 = 8'h77;
        wrvld4  = 1'b1;
        exp4.push_back(8'h77);
        step();
        wrvld4 = 1'b0;
        check("post-reset head", rddata4, 8'h77);
        rdrdy4 = 1'b1;
        step();
        rdrdy4 = 1'b0;
        check("post-reset final cnt", cnt4, 0);

        step();
        check("d4 scoreboard empty", exp4.size(), 0);
        check("d5 scoreboard empty", exp5.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
